// File: rtl/fp_mul_result_fifo.sv
// fp_mul_result_fifo: result buffer behind the single-precision FP multiplier.
// Entries of {oflow, uflow, product} are held in a first-word-fall-through FIFO.
// Two saturating counters record how many accepted results raised underflow or overflow.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both high.
// in_ready and out_valid come only from stored state and never from in_valid or out_ready.
// While in_valid=1 and in_ready=0 the producer keeps its payload stable. This block does
// not check that rule.
module fp_mul_result_fifo #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [31:0]                in_prod,
  input  logic                       in_uflow,
  input  logic                       in_oflow,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [31:0]                out_prod,
  output logic [1:0]                 out_flags,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     level,
  input  logic                       clr_cnt,
  output logic [CNT_W-1:0]           uflow_cnt,
  output logic [CNT_W-1:0]           oflow_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  // Each entry is {oflow, uflow, product} and is stored exactly as received.
  logic [33:0]      mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [CNT_W-1:0] uflow_cnt_q, uflow_cnt_d;
  logic [CNT_W-1:0] oflow_cnt_q, oflow_cnt_d;
  logic             push, pop;

  // Status depends only on the level counter. The head entry is read straight from storage.
  always_comb begin
    in_ready  = (level_q != LVL_W'(DEPTH));
    out_valid = (level_q != '0);
    push      = in_valid & in_ready;
    pop       = out_valid & out_ready;
    out_prod  = mem_q[rd_ptr_q][31:0];
    out_flags = mem_q[rd_ptr_q][33:32];
    level     = level_q;
    uflow_cnt = uflow_cnt_q;
    oflow_cnt = oflow_cnt_q;
  end

  // Next-state logic for the pointers (which wrap modulo DEPTH), the level and the counters.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    uflow_cnt_d = clr_cnt ? '0 : uflow_cnt_q;
    oflow_cnt_d = clr_cnt ? '0 : oflow_cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
    // A clear never drops a push that arrives in the same cycle. Counters hold at all-ones.
    if (push && in_uflow && (uflow_cnt_d != '1)) uflow_cnt_d = uflow_cnt_d + CNT_W'(1);
    if (push && in_oflow && (oflow_cnt_d != '1)) oflow_cnt_d = oflow_cnt_d + CNT_W'(1);
  end

  // Control state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      uflow_cnt_q <= '0;
      oflow_cnt_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      uflow_cnt_q <= uflow_cnt_d;
      oflow_cnt_q <= oflow_cnt_d;
    end
  end

  // Storage write on push. The data array is intentionally not reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_oflow, in_uflow, in_prod};
  end

endmodule

// File: tb/tb_fp_mul_result_fifo.sv
// tb_fp_mul_result_fifo: directed and randomized checks of the multiplier result FIFO.
// The reference model is a queue of {oflow, uflow, prod} entries plus two integer counters.
module tb_fp_mul_result_fifo;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic [31:0]       in_prod = '0;
  logic              in_uflow = 1'b0;
  logic              in_oflow = 1'b0;
  logic              in_ready;
  logic              out_valid;
  logic [31:0]       out_prod;
  logic [1:0]        out_flags;
  logic              out_ready = 1'b0;
  logic [2:0]        level;
  logic              clr_cnt = 1'b0;
  logic [CNT_W-1:0]  uflow_cnt;
  logic [CNT_W-1:0]  oflow_cnt;

  logic [33:0] exp_q[$];
  int          exp_ucnt;
  int          exp_ocnt;
  int          total_cnt;
  int          pass_cnt;

  fp_mul_result_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_prod(in_prod), .in_uflow(in_uflow), .in_oflow(in_oflow),
    .in_ready(in_ready),
    .out_valid(out_valid), .out_prod(out_prod), .out_flags(out_flags), .out_ready(out_ready),
    .level(level), .clr_cnt(clr_cnt), .uflow_cnt(uflow_cnt), .oflow_cnt(oflow_cnt)
  );

  // Clock: 10 time-unit period.
  always #5 clk = ~clk;

  // Driver: apply one cycle of inputs, take the rising edge, then advance the model.
  task automatic drive(input logic v, input logic [31:0] p, input logic uf, input logic of_,
                       input logic ordy, input logic clr);
    bit push, pop;
    int ub, ob;
    in_valid = v; in_prod = p; in_uflow = uf; in_oflow = of_; out_ready = ordy; clr_cnt = clr;
    push = v && (exp_q.size() < DEPTH);
    pop  = ordy && (exp_q.size() > 0);
    @(posedge clk); #1;
    if (pop) void'(exp_q.pop_front());
    if (push) exp_q.push_back({of_, uf, p});
    ub = clr ? 0 : exp_ucnt;
    ob = clr ? 0 : exp_ocnt;
    if (push && uf) ub = (ub + 1 > CMAX) ? CMAX : ub + 1;
    if (push && of_) ob = (ob + 1 > CMAX) ? CMAX : ob + 1;
    exp_ucnt = ub; exp_ocnt = ob;
    in_valid = 1'b0; out_ready = 1'b0; clr_cnt = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clr_cnt = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    exp_ucnt = 0; exp_ocnt = 0;
  endtask

  task automatic test_reset();
    do_reset(2);
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else pass_cnt++;
    total_cnt++; if (level !== 3'd0) $display("FAIL reset_level got=%0d exp=0", level); else pass_cnt++;
    total_cnt++; if (uflow_cnt !== '0) $display("FAIL reset_uflow_cnt got=%0d exp=0", uflow_cnt); else pass_cnt++;
    total_cnt++; if (oflow_cnt !== '0) $display("FAIL reset_oflow_cnt got=%0d exp=0", oflow_cnt); else pass_cnt++;
  endtask

  task automatic test_pass_through();
    drive(1'b1, 32'h40C00000, 1'b0, 1'b0, 1'b1, 1'b0);
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL pt_out_valid got=%b exp=1", out_valid); else pass_cnt++;
    total_cnt++; if (out_prod !== 32'h40C00000) $display("FAIL pt_out_prod got=%h exp=40c00000", out_prod); else pass_cnt++;
    total_cnt++; if (out_flags !== 2'b00) $display("FAIL pt_out_flags got=%b exp=00", out_flags); else pass_cnt++;
    total_cnt++; if (level !== 3'd1) $display("FAIL pt_level1 got=%0d exp=1", level); else pass_cnt++;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    total_cnt++; if (level !== 3'd0) $display("FAIL pt_level0 got=%0d exp=0", level); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL pt_drained got=%b exp=0", out_valid); else pass_cnt++;
  endtask

  task automatic test_fill_drain();
    logic [31:0] vals [4];
    vals[0] = 32'h3F800000; vals[1] = 32'h40000000; vals[2] = 32'h40400000; vals[3] = 32'h40800000;
    for (int i = 0; i < 4; i++) drive(1'b1, vals[i], 1'b0, 1'b0, 1'b0, 1'b0);
    total_cnt++; if (level !== 3'd4) $display("FAIL fill_level got=%0d exp=4", level); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL fill_in_ready got=%b exp=0", in_ready); else pass_cnt++;
    drive(1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 1'b0);
    total_cnt++; if (level !== 3'd4) $display("FAIL fill_5th_level got=%0d exp=4", level); else pass_cnt++;
    total_cnt++; if (uflow_cnt !== CNT_W'(exp_ucnt)) $display("FAIL fill_5th_ucnt got=%0d exp=%0d", uflow_cnt, exp_ucnt); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      total_cnt++; if (out_prod !== vals[i]) $display("FAIL drain_prod%0d got=%h exp=%h", i, out_prod, vals[i]); else pass_cnt++;
      // Pop while full with a push offered: the push must not be taken.
      drive(i == 0, 32'h12345678, 1'b0, 1'b0, 1'b1, 1'b0);
      total_cnt++; if (level !== 3'(3 - i)) $display("FAIL drain_level%0d got=%0d exp=%0d", i, level, 3 - i); else pass_cnt++;
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL drain_in_ready%0d got=%b exp=1", i, in_ready); else pass_cnt++;
    end
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL drain_empty got=%b exp=0", out_valid); else pass_cnt++;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    total_cnt++; if (level !== 3'd0) $display("FAIL empty_pop_level got=%0d exp=0", level); else pass_cnt++;
  endtask

  task automatic test_concurrent();
    logic [31:0] p;
    for (int i = 0; i < 2; i++) drive(1'b1, $urandom, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      total_cnt++; if ({out_flags, out_prod} !== exp_q[0]) $display("FAIL conc_head%0d got=%h exp=%h", i, {out_flags, out_prod}, exp_q[0]); else pass_cnt++;
      p = $urandom;
      drive(1'b1, p, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 1'b0);
      total_cnt++; if (level !== 3'd2) $display("FAIL conc_level%0d got=%0d exp=2", i, level); else pass_cnt++;
    end
    total_cnt++; if (uflow_cnt !== CNT_W'(exp_ucnt)) $display("FAIL conc_ucnt got=%0d exp=%0d", uflow_cnt, exp_ucnt); else pass_cnt++;
    total_cnt++; if (oflow_cnt !== CNT_W'(exp_ocnt)) $display("FAIL conc_ocnt got=%0d exp=%0d", oflow_cnt, exp_ocnt); else pass_cnt++;
  endtask

  task automatic test_counters();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    total_cnt++; if (uflow_cnt !== '0) $display("FAIL clr_ucnt got=%0d exp=0", uflow_cnt); else pass_cnt++;
    for (int i = 0; i < 3; i++) drive(1'b1, $urandom, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) drive(1'b1, $urandom, 1'b0, 1'b1, 1'b1, 1'b0);
    total_cnt++; if (uflow_cnt !== 4'd3) $display("FAIL cnt_ucnt got=%0d exp=3", uflow_cnt); else pass_cnt++;
    total_cnt++; if (oflow_cnt !== 4'd2) $display("FAIL cnt_ocnt got=%0d exp=2", oflow_cnt); else pass_cnt++;
    drive(1'b1, $urandom, 1'b1, 1'b0, 1'b1, 1'b1);
    total_cnt++; if (uflow_cnt !== 4'd1) $display("FAIL clr_push_ucnt got=%0d exp=1", uflow_cnt); else pass_cnt++;
    total_cnt++; if (oflow_cnt !== 4'd0) $display("FAIL clr_push_ocnt got=%0d exp=0", oflow_cnt); else pass_cnt++;
    // Both flags on one push: both counters step, entry keeps both flags.
    while (exp_q.size() > 0) drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 32'h7F800000, 1'b1, 1'b1, 1'b0, 1'b0);
    total_cnt++; if (out_flags !== 2'b11) $display("FAIL both_flags got=%b exp=11", out_flags); else pass_cnt++;
    total_cnt++; if (uflow_cnt !== 4'd2) $display("FAIL both_ucnt got=%0d exp=2", uflow_cnt); else pass_cnt++;
    total_cnt++; if (oflow_cnt !== 4'd1) $display("FAIL both_ocnt got=%0d exp=1", oflow_cnt); else pass_cnt++;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_saturation();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 17; i++) drive(1'b1, $urandom, 1'b1, 1'b0, 1'b1, 1'b0);
    total_cnt++; if (uflow_cnt !== 4'd15) $display("FAIL sat_ucnt got=%0d exp=15", uflow_cnt); else pass_cnt++;
    total_cnt++; if (oflow_cnt !== 4'd0) $display("FAIL sat_ocnt got=%0d exp=0", oflow_cnt); else pass_cnt++;
    drive(1'b1, $urandom, 1'b1, 1'b0, 1'b1, 1'b1);
    total_cnt++; if (uflow_cnt !== 4'd1) $display("FAIL sat_clr_ucnt got=%0d exp=1", uflow_cnt); else pass_cnt++;
  endtask

  task automatic test_reset_midstream();
    while (exp_q.size() > 0) drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, $urandom, 1'b1, 1'b1, 1'b0, 1'b0);
    total_cnt++; if (level !== 3'd3) $display("FAIL mid_pre_level got=%0d exp=3", level); else pass_cnt++;
    do_reset(1);
    total_cnt++; if (level !== 3'd0) $display("FAIL mid_level got=%0d exp=0", level); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL mid_out_valid got=%b exp=0", out_valid); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL mid_in_ready got=%b exp=1", in_ready); else pass_cnt++;
    total_cnt++; if (uflow_cnt !== '0 || oflow_cnt !== '0) $display("FAIL mid_cnts got=%0d/%0d exp=0/0", uflow_cnt, oflow_cnt); else pass_cnt++;
  endtask

  task automatic test_random();
    logic        v, uf, of_;
    logic [31:0] p;
    logic        hold;
    hold = 1'b0; v = 1'b0; uf = 1'b0; of_ = 1'b0; p = '0;
    for (int i = 0; i < 300; i++) begin
      total_cnt++; if (level !== 3'(exp_q.size())) $display("FAIL rnd_level%0d got=%0d exp=%0d", i, level, exp_q.size()); else pass_cnt++;
      total_cnt++; if (in_ready !== (exp_q.size() != DEPTH)) $display("FAIL rnd_in_ready%0d got=%b", i, in_ready); else pass_cnt++;
      total_cnt++; if (out_valid !== (exp_q.size() != 0)) $display("FAIL rnd_out_valid%0d got=%b", i, out_valid); else pass_cnt++;
      if (exp_q.size() != 0) begin
        total_cnt++; if ({out_flags, out_prod} !== exp_q[0]) $display("FAIL rnd_head%0d got=%h exp=%h", i, {out_flags, out_prod}, exp_q[0]); else pass_cnt++;
      end
      total_cnt++; if (uflow_cnt !== CNT_W'(exp_ucnt) || oflow_cnt !== CNT_W'(exp_ocnt))
        $display("FAIL rnd_cnts%0d got=%0d/%0d exp=%0d/%0d", i, uflow_cnt, oflow_cnt, exp_ucnt, exp_ocnt); else pass_cnt++;
      // A stalled push keeps its payload until accepted.
      if (!hold) begin
        v = 1'($urandom_range(0, 3) != 0); p = $urandom;
        uf = 1'($urandom_range(0, 2) == 0); of_ = 1'($urandom_range(0, 3) == 0);
      end
      hold = v && (exp_q.size() == DEPTH);
      drive(v, p, uf, of_, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 40) == 0));
    end
  endtask

  initial begin
    total_cnt = 0; pass_cnt = 0; exp_ucnt = 0; exp_ocnt = 0;
    test_reset();
    test_pass_through();
    test_fill_drain();
    test_concurrent();
    test_counters();
    test_saturation();
    test_reset_midstream();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
